// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequential ALU with a multi-cycle shift-add multiplier.
//
// A start accepted in IDLE or DONE latches op/A/B/C0. Single-cycle ops pass
// through EXEC; MUL spends WIDTH cycles in MUL (one multiplier bit per cycle).
// All results and flags are registered and change only on entry to DONE.
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst            synchronous active-high reset
//   i_start          request an operation (ignored while o_busy)
//   i_op[2:0]        000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                    101 SHL, 110 SHR, 111 MUL (unsigned)
//   i_a, i_b         operands; i_b[$clog2(WIDTH)-1:0] is the shift amount
//   i_c0             carry-in (ADD) / borrow-in (SUB)
//   o_busy           high in EXEC and MUL
//   o_done           one-cycle pulse in DONE
//   o_f, o_h         result / high half of MUL product (0 for other ops)
//   o_c4             bit WIDTH of the ADD/SUB result, carry/shift-out otherwise
//   o_cf,o_zf,o_sf,o_of  carry, zero, sign, signed-overflow flags
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c0,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_f,
  output logic [WIDTH-1:0] o_h,
  output logic             o_c4,
  output logic             o_cf,
  output logic             o_zf,
  output logic             o_sf,
  output logic             o_of
);

  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_load;

  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_c0;
  logic [SW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;

  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_f;
  logic [WIDTH-1:0]   r_h;
  logic               r_c4;
  logic               r_cf;
  logic               r_zf;
  logic               r_sf;
  logic               r_of;

  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [SW-1:0]      w_amt;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_next;

  logic [WIDTH-1:0]   w_f;
  logic [WIDTH-1:0]   w_h;
  logic               w_c4;
  logic               w_cf;
  logic               w_of;
  logic               w_zf;

  // Both arithmetic paths are (WIDTH+1) bits so bit WIDTH is the raw C4.
  assign w_add = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_c0};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b} - {{WIDTH{1'b0}}, r_c0};

  // The extra bit on each side catches the last bit shifted out.
  assign w_amt = r_b[SW-1:0];
  assign w_shl = {1'b0, r_a} << w_amt;
  assign w_shr = {r_a, 1'b0} >> w_amt;

  // Shift-add step: r_prod = {partial product, unconsumed multiplier bits}.
  assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                     + (r_prod[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};

  assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));
  // DONE is never followed by DONE, so entering it means results are ready.
  assign w_load   = (w_next == DONE);

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          w_next = (i_op == OP_MUL) ? MUL : EXEC;
        end else begin
          w_next = IDLE;
        end
      end
      EXEC: w_next = DONE;
      MUL: begin
        if (r_cnt == LAST) begin
          w_next = DONE;
        end else begin
          w_next = MUL;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Result and flag values to be captured on entry to DONE.
  always_comb begin
    w_f  = {WIDTH{1'b0}};
    w_h  = {WIDTH{1'b0}};
    w_c4 = 1'b0;
    w_cf = 1'b0;
    w_of = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_f  = w_add[WIDTH-1:0];
        w_c4 = w_add[WIDTH];
        w_cf = w_add[WIDTH];
        w_of = (r_a[M] == r_b[M]) && (w_add[M] != r_a[M]);
      end
      OP_SUB: begin
        w_f  = w_sub[WIDTH-1:0];
        w_c4 = w_sub[WIDTH];
        w_cf = ~w_sub[WIDTH];
        w_of = (r_a[M] != r_b[M]) && (w_sub[M] != r_a[M]);
      end
      OP_AND: w_f = r_a & r_b;
      OP_OR:  w_f = r_a | r_b;
      OP_XOR: w_f = r_a ^ r_b;
      OP_SHL: begin
        w_f  = w_shl[WIDTH-1:0];
        w_c4 = w_shl[WIDTH];
        w_cf = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_f  = w_shr[WIDTH:1];
        w_c4 = w_shr[0];
        w_cf = w_shr[0];
      end
      OP_MUL: begin
        w_f  = w_prod_next[WIDTH-1:0];
        w_h  = w_prod_next[2*WIDTH-1:WIDTH];
        w_c4 = (w_h != {WIDTH{1'b0}});
        w_cf = (w_h != {WIDTH{1'b0}});
      end
      default: w_f = {WIDTH{1'b0}};
    endcase
    // w_h is zero for every non-MUL op, so one expression covers all cases.
    w_zf = (w_f == {WIDTH{1'b0}}) && (w_h == {WIDTH{1'b0}});
  end

  // State, operand latches, multiplier iteration and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_op    <= 3'b000;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_c0    <= 1'b0;
      r_cnt   <= {SW{1'b0}};
      r_prod  <= {(2*WIDTH){1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_f     <= {WIDTH{1'b0}};
      r_h     <= {WIDTH{1'b0}};
      r_c4    <= 1'b0;
      r_cf    <= 1'b0;
      r_zf    <= 1'b0;
      r_sf    <= 1'b0;
      r_of    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == EXEC) || (w_next == MUL);
      r_done  <= (w_next == DONE);
      if (w_accept) begin
        r_op   <= i_op;
        r_a    <= i_a;
        r_b    <= i_b;
        r_c0   <= i_c0;
        r_cnt  <= {SW{1'b0}};
        r_prod <= {{WIDTH{1'b0}}, i_b};
      end else if (r_state == MUL) begin
        r_cnt  <= r_cnt + SW'(1);
        r_prod <= w_prod_next;
      end
      if (w_load) begin
        r_f  <= w_f;
        r_h  <= w_h;
        r_c4 <= w_c4;
        r_cf <= w_cf;
        r_zf <= w_zf;
        r_sf <= w_f[M];
        r_of <= w_of;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_f    = r_f;
  assign o_h    = r_h;
  assign o_c4   = r_c4;
  assign o_cf   = r_cf;
  assign o_zf   = r_zf;
  assign o_sf   = r_sf;
  assign o_of   = r_of;

endmodule
